// File: rtl/fifo_wr_ctrl_if.sv
// Write-side handshake of the async FIFO: request/clear in, RAM strobe,
// Gray pointer and status flags out.
interface fifo_wr_ctrl_if #(
  parameter int AW = 3
);
  logic          w_inc;
  logic          w_ovf_clr;
  logic [AW:0]   gray_r_ptr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW:0]   gray_w_ptr;
  logic          w_full;
  logic          w_almost_full;
  logic [AW:0]   w_level;
  logic          w_overflow;

  modport master (
    output w_inc, w_ovf_clr, gray_r_ptr,
    input  w_en, w_addr, gray_w_ptr, w_full, w_almost_full, w_level, w_overflow
  );

  modport slave (
    input  w_inc, w_ovf_clr, gray_r_ptr,
    output w_en, w_addr, gray_w_ptr, w_full, w_almost_full, w_level, w_overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, RAM write
// strobe, full/almost-full, occupancy and sticky overflow.
module fifo_wr_ctrl #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic         w_clk,
  input  logic         w_rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);

  logic [AW:0] w_ptr, w_ptr_next, gray_next, gray_w_q;
  logic [AW:0] r_bin, level_next, level_q;
  logic        full, en, af_q, ovf_q;

  // Full when the write Gray pointer equals the read Gray pointer with
  // its two MSBs inverted, i.e. exactly DEPTH entries apart.
  assign full = (gray_w_q == {~bus.gray_r_ptr[AW:AW-1], bus.gray_r_ptr[AW-2:0]});
  assign en   = bus.w_inc & ~full;

  assign w_ptr_next = w_ptr + (AW+1)'(en);
  assign gray_next  = w_ptr_next ^ (w_ptr_next >> 1);

  always_comb begin
    r_bin     = '0;
    r_bin[AW] = bus.gray_r_ptr[AW];
    for (int i = AW-1; i >= 0; i--)
      r_bin[i] = r_bin[i+1] ^ bus.gray_r_ptr[i];
  end

  // A lagging read pointer can only overstate occupancy, never understate it.
  assign level_next = w_ptr_next - r_bin;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_ptr    <= '0;
      gray_w_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      w_ptr    <= w_ptr_next;
      gray_w_q <= gray_next;
      level_q  <= level_next;
      af_q     <= (level_next >= AF_THR);
      if (bus.w_inc && full)  ovf_q <= 1'b1;
      else if (bus.w_ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.w_en          = en;
  assign bus.w_addr        = w_ptr[AW-1:0];
  assign bus.gray_w_ptr    = gray_w_q;
  assign bus.w_full        = full;
  assign bus.w_almost_full = af_q;
  assign bus.w_level       = level_q;
  assign bus.w_overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised and directed check of fifo_wr_ctrl against a counting model
// of writes and reads (DEPTH=8, AF_LEVEL=6).
module tb_fifo_wr_ctrl;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AW    = 3;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  fifo_wr_ctrl_if #(.AW(AW)) bus ();

  fifo_wr_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus.slave)
  );

  always #5 w_clk = ~w_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: total writes accepted and total reads seen since reset
  int wr = 0, rd = 0;
  bit m_ovf = 0;
  int m_level = 0;
  bit m_af = 0;
  bit saw_wrap = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic cyc(input bit rst, input bit inc, input bit clr, input int rd_new);
    bit ex_full, ex_en;
    int prev_g;
    rd = rd_new;
    w_rst = rst;
    bus.w_inc = inc;
    bus.w_ovf_clr = clr;
    bus.gray_r_ptr = gray4(rd);
    #1;
    ex_full = ((wr - rd) % 16) == DEPTH;
    ex_en   = inc && !ex_full;
    if (!rst) begin
      check("w_full", int'(bus.w_full), int'(ex_full));
      check("w_en",   int'(bus.w_en),   int'(ex_en));
      check("w_addr", int'(bus.w_addr), wr % DEPTH);
    end
    prev_g = int'(bus.gray_w_ptr);
    @(posedge w_clk);
    if (rst) begin
      wr = 0; rd = 0; m_ovf = 0; m_level = 0; m_af = 0;
    end else begin
      if (ex_en) wr++;
      m_level = (wr - rd) % 16;
      m_af    = m_level >= AF;
      if (inc && ex_full) m_ovf = 1;
      else if (clr)       m_ovf = 0;
    end
    #1;
    check("gray_w_ptr", int'(bus.gray_w_ptr), int'(gray4(wr)));
    check("w_level",    int'(bus.w_level),    m_level);
    check("w_almost_full", int'(bus.w_almost_full), int'(m_af));
    check("w_overflow", int'(bus.w_overflow), int'(m_ovf));
    if (prev_g == 8 && bus.gray_w_ptr == 4'b0000) saw_wrap = 1;
  endtask

  initial begin
    bus.w_inc = 0; bus.w_ovf_clr = 0; bus.gray_r_ptr = '0;

    // 1: reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_level", int'(bus.w_level), 0);
    check("rst_ovf",   int'(bus.w_overflow), 0);

    // 2: fill to full
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0);
      if (i == 5) check("af_after6", int'(bus.w_almost_full), 1);
      if (i == 4) check("af_after5", int'(bus.w_almost_full), 0);
    end
    check("full_gray", int'(bus.gray_w_ptr), 4'b1100);
    check("full_level", int'(bus.w_level), 8);
    #1 check("full_flag", int'(bus.w_full), 1);

    // 3: overflow then clear
    cyc(0, 1, 0, 0);
    check("ovf_set", int'(bus.w_overflow), 1);
    check("ovf_gray_hold", int'(bus.gray_w_ptr), 4'b1100);
    cyc(0, 1, 1, 0);                       // set wins over clear
    check("ovf_setwins", int'(bus.w_overflow), 1);
    cyc(0, 0, 1, 0);
    check("ovf_clr", int'(bus.w_overflow), 0);

    // 4: one read frees a slot
    cyc(0, 1, 0, 1);
    check("refill_gray", int'(bus.gray_w_ptr), 4'b1101);
    #1 check("refull_flag", int'(bus.w_full), 1);

    // 5: wrap-around with read pointer trailing by two
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 0, wr - 1);
      check("wrap_level", int'(bus.w_level), 2);
    end
    check("wrap_seen", int'(saw_wrap), 1);

    // 6: reset mid-burst
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("midrst_gray", int'(bus.gray_w_ptr), 0);
    check("midrst_level", int'(bus.w_level), 0);
    #1 check("midrst_addr", int'(bus.w_addr), 0);

    // random traffic; read side may jump several entries but never passes writes
    for (int i = 0; i < 400; i++) begin
      bit r_rst, r_inc, r_clr;
      int r_nxt;
      r_rst = ($urandom_range(99) == 0);
      r_inc = ($urandom_range(9) < 7);
      r_clr = ($urandom_range(9) == 0);
      r_nxt = rd + int'($urandom_range(3));
      if ($urandom_range(3) != 0) r_nxt = rd;
      if (r_nxt > wr) r_nxt = wr;
      cyc(r_rst, r_inc, r_clr, r_nxt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
